mac_tx_framer: RTL

MAC_TX_FRAMER -- requirements
Module: mac_tx_framer

---
 rtl/mac_tx_framer.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/mac_tx_framer.sv
// MII transmit framer: wraps a streamed payload with preamble, SFD, Ethernet
// header, zero padding and CRC-32 FCS, then enforces the inter-packet gap.
// All outputs are registered; r_state names the octet currently on out_txd.
module mac_tx_framer #(
  parameter logic [47:0] DEST_MAC    = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01,
  parameter logic [15:0] ETHER_TYPE  = 16'h0800,
  parameter int unsigned MIN_PAYLOAD = 46,
  parameter int unsigned MAX_PAYLOAD = 1500,
  parameter int unsigned IPG_BYTES   = 12
) (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic       in_valid,
  input  logic [7:0] in_txd,
  input  logic       in_last,
  output logic       out_tx_ready,
  output logic       out_txen,
  output logic [7:0] out_txd,
  output logic       out_tx_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_PREAMBLE, S_SFD, S_MACDEST, S_MACSRC,
    S_ETHERTYPE, S_PAYLOAD, S_PAD, S_FCS, S_IPG
  } state_t;

  localparam logic [10:0] LP_MAX      = 11'(MAX_PAYLOAD);
  localparam logic [10:0] LP_MIN      = 11'(MIN_PAYLOAD);
  localparam logic [15:0] LP_IPG_LAST = 16'(IPG_BYTES - 1);

  state_t      r_state, w_state;
  logic [15:0] r_idx, w_idx;
  logic [10:0] r_pcnt, w_pcnt;
  logic [31:0] r_crc, w_crc;
  logic        r_txen, w_txen;
  logic [7:0]  r_txd, w_txd;
  logic        r_ready, w_ready;
  logic        r_err, w_err;
  logic        w_crc_en;

  // Reflected CRC-32 (poly 0xEDB88320) advanced by one octet.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x;
    x = c ^ {24'd0, d};
    for (int unsigned b = 0; b < 8; b++) begin
      x = x[0] ? ((x >> 1) ^ 32'hEDB8_8320) : (x >> 1);
    end
    return x;
  endfunction

  // Octet i of a MAC address, most-significant octet first.
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] i);
    logic [47:0] s;
    s = mac >> (6'd40 - {i, 3'b000});
    return s[7:0];
  endfunction

  // Octet i of the complemented CRC, least-significant octet first.
  function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] i);
    logic [31:0] s;
    s = ~crc;
    s = s >> {i, 3'b000};
    return s[7:0];
  endfunction

  // Next-state and next-output decode; every output is computed one cycle ahead.
  always_comb begin
    w_state  = r_state;
    w_idx    = r_idx;
    w_pcnt   = r_pcnt;
    w_crc    = r_crc;
    w_txen   = 1'b0;
    w_txd    = '0;
    w_ready  = 1'b0;
    w_err    = 1'b0;
    w_crc_en = 1'b0;
    // r_ready is high only in the last EtherType cycle and during payload,
    // so the accept/underrun decision is shared by both states here.
    if (r_ready) begin
      if (in_valid) begin
        w_state  = S_PAYLOAD;
        w_txen   = 1'b1;
        w_txd    = in_txd;
        w_crc_en = 1'b1;
        w_pcnt   = r_pcnt + 11'd1;
        w_ready  = !(in_last || ((r_pcnt + 11'd1) == LP_MAX));
      end else begin
        w_state = S_IPG;
        w_idx   = '0;
        w_err   = 1'b1;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          w_pcnt = '0;
          w_idx  = '0;
          w_crc  = '1;
          if (in_valid) begin
            w_state = S_PREAMBLE;
            w_txen  = 1'b1;
            w_txd   = 8'h55;
          end
        end
        S_PREAMBLE: begin
          w_txen = 1'b1;
          w_pcnt = '0;
          w_crc  = '1;
          if (r_idx == 16'd6) begin
            w_state = S_SFD;
            w_idx   = '0;
            w_txd   = 8'hD5;
          end else begin
            w_idx = r_idx + 16'd1;
            w_txd = 8'h55;
          end
        end
        S_SFD: begin
          w_state  = S_MACDEST;
          w_idx    = '0;
          w_txen   = 1'b1;
          w_txd    = mac_byte(DEST_MAC, 3'd0);
          w_crc_en = 1'b1;
        end
        S_MACDEST: begin
          w_txen   = 1'b1;
          w_crc_en = 1'b1;
          if (r_idx == 16'd5) begin
            w_state = S_MACSRC;
            w_idx   = '0;
            w_txd   = mac_byte(SRC_MAC, 3'd0);
          end else begin
            w_idx = r_idx + 16'd1;
            w_txd = mac_byte(DEST_MAC, r_idx[2:0] + 3'd1);
          end
        end
        S_MACSRC: begin
          w_txen   = 1'b1;
          w_crc_en = 1'b1;
          if (r_idx == 16'd5) begin
            w_state = S_ETHERTYPE;
            w_idx   = '0;
            w_txd   = ETHER_TYPE[15:8];
          end else begin
            w_idx = r_idx + 16'd1;
            w_txd = mac_byte(SRC_MAC, r_idx[2:0] + 3'd1);
          end
        end
        S_ETHERTYPE: begin
          // Raising ready with the final header octet lets the first payload
          // byte follow with no idle octet in between.
          w_txen   = 1'b1;
          w_crc_en = 1'b1;
          w_idx    = 16'd1;
          w_txd    = ETHER_TYPE[7:0];
          w_ready  = 1'b1;
        end
        S_PAYLOAD, S_PAD: begin
          w_txen = 1'b1;
          if (r_pcnt < LP_MIN) begin
            w_state  = S_PAD;
            w_txd    = 8'h00;
            w_crc_en = 1'b1;
            w_pcnt   = r_pcnt + 11'd1;
          end else begin
            w_state = S_FCS;
            w_idx   = '0;
            w_txd   = fcs_byte(r_crc, 2'd0);
          end
        end
        S_FCS: begin
          if (r_idx == 16'd3) begin
            w_state = S_IPG;
            w_idx   = '0;
          end else begin
            w_txen = 1'b1;
            w_idx  = r_idx + 16'd1;
            w_txd  = fcs_byte(r_crc, r_idx[1:0] + 2'd1);
          end
        end
        S_IPG: begin
          if (r_idx == LP_IPG_LAST) begin
            w_idx = '0;
            if (in_valid) begin
              w_state = S_PREAMBLE;
              w_txen  = 1'b1;
              w_txd   = 8'h55;
            end else begin
              w_state = S_IDLE;
            end
          end else begin
            w_idx = r_idx + 16'd1;
          end
        end
        default: w_state = S_IDLE;
      endcase
    end
    if (w_crc_en) w_crc = crc_byte(r_crc, w_txd);
  end

  // State, counters, CRC and registered outputs.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_pcnt  <= '0;
      r_crc   <= '1;
      r_txen  <= 1'b0;
      r_txd   <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_idx   <= w_idx;
      r_pcnt  <= w_pcnt;
      r_crc   <= w_crc;
      r_txen  <= w_txen;
      r_txd   <= w_txd;
      r_ready <= w_ready;
      r_err   <= w_err;
    end
  end

  assign out_tx_ready = r_ready;
  assign out_txen     = r_txen;
  assign out_txd      = r_txd;
  assign out_tx_err   = r_err;

endmodule
